stage_mem_lsu: RTL and testbench

- MEM stage of the 5-stage RISC-V pipeline, between the EX/MEM register and the WB stage.
- Executes loads and stores against a request/acknowledge data-memory port, with byte/half/word sizing, sign/zero extension and misalignment detection.
- Owns the MEM/WB pipeline register.
- Asserts mem_stall while a memory access is outstanding, so upstream stages hold.

---
 rtl/stage_mem_lsu.sv | 175 +++++++++++++++++
 tb/tb_stage_mem_lsu.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_mem_lsu.sv
// MEM stage of the 5-stage RISC-V pipeline: load/store unit on a req/ack data port
// plus the MEM/WB pipeline register. fsm_state exposes the FSM (0 = IDLE, 1 = BUSY).
module stage_mem_lsu #(
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  EX_MEM_valid,
  input  logic [REG_WIDTH-1:0]  EX_MEM_alu_out,
  input  logic [REG_WIDTH-1:0]  EX_MEM_rs2_data,
  input  logic                  EX_MEM_mem_read,
  input  logic                  EX_MEM_mem_write,
  input  logic [2:0]            EX_MEM_funct3,
  input  logic                  EX_MEM_reg_write_en,
  input  logic [RD_WIDTH-1:0]   EX_MEM_rd,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]           dmem_wdata,
  output logic [3:0]            dmem_wstrb,
  input  logic                  dmem_ack,
  input  logic [31:0]           dmem_rdata,
  output logic                  mem_stall,
  output logic                  MEM_WB_valid,
  output logic [REG_WIDTH-1:0]  MEM_WB_alu_out,
  output logic                  MEM_WB_reg_wb_sel,
  output logic                  MEM_WB_reg_write_en,
  output logic [RD_WIDTH-1:0]   MEM_WB_rd,
  output logic                  misalign_err,
  output logic                  fsm_state
);

  // Handshake: dmem_req rises on the edge after an aligned memop is seen in IDLE and
  // stays high with all dmem_* stable until the cycle dmem_ack=1; it drops on that edge.
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                state, state_next;
  logic                  memop, is_store, illegal, misaligned, bad_access, start_access;
  logic [ADDR_WIDTH-1:0] eff_addr;
  logic [1:0]            offset;
  logic [3:0]            st_wstrb;
  logic [31:0]           st_wdata;
  logic [7:0]            lane_byte;
  logic [15:0]           lane_half;
  logic [31:0]           load_data;
  logic [2:0]            lat_funct3;
  logic [1:0]            lat_offset;
  logic                  lat_rwe;
  logic [RD_WIDTH-1:0]   lat_rd;

  assign fsm_state = state;

  always_comb begin
    memop    = EX_MEM_valid & (EX_MEM_mem_read | EX_MEM_mem_write);
    is_store = EX_MEM_mem_write;
    eff_addr = ADDR_WIDTH'(EX_MEM_alu_out);
    offset   = eff_addr[1:0];
    if (is_store) illegal = !(EX_MEM_funct3 inside {3'b000, 3'b001, 3'b010});
    else          illegal = !(EX_MEM_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned   = ((EX_MEM_funct3[1:0] == 2'b10) && (offset != 2'b00)) ||
                   ((EX_MEM_funct3[1:0] == 2'b01) && offset[0]);
    bad_access   = memop & (illegal | misaligned);
    start_access = memop & ~bad_access;
  end

  // Store data is replicated across lanes so the strobes alone select the bytes.
  always_comb begin
    st_wstrb = 4'b1111;
    st_wdata = EX_MEM_rs2_data[31:0];
    case (EX_MEM_funct3[1:0])
      2'b00: begin
        st_wstrb = 4'b0001 << offset;
        st_wdata = {4{EX_MEM_rs2_data[7:0]}};
      end
      2'b01: begin
        st_wstrb = offset[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{EX_MEM_rs2_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_byte = dmem_rdata[8*lat_offset +: 8];
    lane_half = lat_offset[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (lat_funct3)
      3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_data = {24'b0, lane_byte};
      3'b101:  load_data = {16'b0, lane_half};
      default: load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_access) state_next = BUSY;
      BUSY:    if (dmem_ack)     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_stall = 1'b0;
    case (state)
      IDLE:    mem_stall = start_access;
      BUSY:    mem_stall = ~dmem_ack;
      default: mem_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dmem_req            <= 1'b0;
      dmem_we             <= 1'b0;
      dmem_addr           <= '0;
      dmem_wdata          <= '0;
      dmem_wstrb          <= '0;
      lat_funct3          <= '0;
      lat_offset          <= '0;
      lat_rwe             <= 1'b0;
      lat_rd              <= '0;
      MEM_WB_valid        <= 1'b0;
      MEM_WB_alu_out      <= '0;
      MEM_WB_reg_wb_sel   <= 1'b0;
      MEM_WB_reg_write_en <= 1'b0;
      MEM_WB_rd           <= '0;
      misalign_err        <= 1'b0;
    end else begin
      misalign_err        <= 1'b0;
      MEM_WB_valid        <= 1'b0;
      MEM_WB_reg_wb_sel   <= 1'b0;
      MEM_WB_reg_write_en <= 1'b0;
      if (state == IDLE) begin
        if (EX_MEM_valid && !memop) begin
          MEM_WB_valid        <= 1'b1;
          MEM_WB_alu_out      <= EX_MEM_alu_out;
          MEM_WB_reg_wb_sel   <= 1'b1;
          MEM_WB_reg_write_en <= EX_MEM_reg_write_en;
          MEM_WB_rd           <= EX_MEM_rd;
        end else if (bad_access) begin
          misalign_err <= 1'b1;
          MEM_WB_valid <= 1'b1;
          MEM_WB_rd    <= EX_MEM_rd;
        end else if (start_access) begin
          dmem_req   <= 1'b1;
          dmem_we    <= is_store;
          dmem_addr  <= {eff_addr[ADDR_WIDTH-1:2], 2'b00};
          dmem_wdata <= is_store ? st_wdata : 32'b0;
          dmem_wstrb <= is_store ? st_wstrb : 4'b0;
          lat_funct3 <= EX_MEM_funct3;
          lat_offset <= offset;
          lat_rwe    <= EX_MEM_reg_write_en;
          lat_rd     <= EX_MEM_rd;
        end
      end else if (dmem_ack) begin
        dmem_req            <= 1'b0;
        MEM_WB_valid        <= 1'b1;
        MEM_WB_alu_out      <= REG_WIDTH'(load_data);
        MEM_WB_reg_wb_sel   <= 1'b1;
        MEM_WB_reg_write_en <= lat_rwe & ~dmem_we;
        MEM_WB_rd           <= lat_rd;
      end
    end
  end

endmodule

// File: tb/tb_stage_mem_lsu.sv
// Directed and randomized bench for stage_mem_lsu; expectations come from a
// behavioural model of the load/store rules and a queue of expected writebacks.
module tb_stage_mem_lsu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        EX_MEM_valid, EX_MEM_mem_read, EX_MEM_mem_write, EX_MEM_reg_write_en;
  logic [31:0] EX_MEM_alu_out, EX_MEM_rs2_data;
  logic [2:0]  EX_MEM_funct3;
  logic [4:0]  EX_MEM_rd;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        mem_stall, MEM_WB_valid, MEM_WB_reg_wb_sel, MEM_WB_reg_write_en;
  logic [31:0] MEM_WB_alu_out;
  logic [4:0]  MEM_WB_rd;
  logic        misalign_err, fsm_state;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] req_addr_q[$];
  int req_pulses = 0;
  int retires = 0;
  logic req_q = 1'b0;

  stage_mem_lsu dut (
    .clk(clk), .reset_n(reset_n),
    .EX_MEM_valid(EX_MEM_valid), .EX_MEM_alu_out(EX_MEM_alu_out),
    .EX_MEM_rs2_data(EX_MEM_rs2_data), .EX_MEM_mem_read(EX_MEM_mem_read),
    .EX_MEM_mem_write(EX_MEM_mem_write), .EX_MEM_funct3(EX_MEM_funct3),
    .EX_MEM_reg_write_en(EX_MEM_reg_write_en), .EX_MEM_rd(EX_MEM_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .MEM_WB_valid(MEM_WB_valid),
    .MEM_WB_alu_out(MEM_WB_alu_out), .MEM_WB_reg_wb_sel(MEM_WB_reg_wb_sel),
    .MEM_WB_reg_write_en(MEM_WB_reg_write_en), .MEM_WB_rd(MEM_WB_rd),
    .misalign_err(misalign_err), .fsm_state(fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Request-pulse and retirement monitor
  always @(negedge clk) begin
    if (dmem_req && !req_q) begin
      req_pulses++;
      req_addr_q.push_back(dmem_addr);
    end
    req_q = dmem_req;
    if (MEM_WB_valid) retires++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: legality, store lanes, load extraction
  function automatic bit ref_bad(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int bytes;
    bit legal;
    legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 1'b1;
    bytes = 1 << f3[1:0];
    return (a % bytes) != 0;
  endfunction

  function automatic logic [3:0] ref_wstrb(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = 1 << f3[1:0];
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1:0] == 2'd0) return (d % 256) * 32'h01010101;
    if (f3[1:0] == 2'd1) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] v;
    logic [7:0]  b;
    logic [15:0] h;
    v = w >> ((a % 4) * 8);
    b = v[7:0];
    h = v[15:0];
    case (f3)
      3'd0:    return 32'($signed(b));
      3'd1:    return 32'($signed(h));
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return w;
    endcase
  endfunction

  // Driver: present one instruction, play the memory side, check every cycle
  task automatic do_op(input string tag, input bit valid, input bit rd_op, input bit wr_op,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rs2,
                       input bit rwe, input logic [4:0] rd, input int waits,
                       input logic [31:0] rdata);
    bit memop, st, bad;
    logic [31:0] got;
    memop = valid && (rd_op || wr_op);
    st    = wr_op;
    bad   = memop && ref_bad(st, f3, alu);
    EX_MEM_valid = valid; EX_MEM_mem_read = rd_op; EX_MEM_mem_write = wr_op;
    EX_MEM_funct3 = f3; EX_MEM_alu_out = alu; EX_MEM_rs2_data = rs2;
    EX_MEM_reg_write_en = rwe; EX_MEM_rd = rd;
    #1;
    if (!memop || bad) begin
      chk({tag, ".stall"}, mem_stall, 0);
      if (valid && !memop) exp_q.push_back(alu);
      @(posedge clk); #1; EX_MEM_valid = 1'b0; #1;
      chk({tag, ".wb_valid"}, MEM_WB_valid, valid);
      chk({tag, ".misalign"}, misalign_err, bad);
      chk({tag, ".req"}, dmem_req, 0);
      if (valid) begin
        chk({tag, ".wb_wen"}, MEM_WB_reg_write_en, bad ? 1'b0 : rwe);
        chk({tag, ".wb_rd"}, MEM_WB_rd, rd);
      end
      if (valid && !memop) begin
        chk({tag, ".wb_sel"}, MEM_WB_reg_wb_sel, 1);
        got = exp_q.pop_front();
        chk({tag, ".wb_data"}, MEM_WB_alu_out, got);
      end
      if (bad) begin
        @(posedge clk); #2;
        chk({tag, ".misalign_off"}, misalign_err, 0);
        chk({tag, ".req_off"}, dmem_req, 0);
      end
    end else begin
      chk({tag, ".stall_req"}, mem_stall, 1);
      exp_q.push_back(st ? 32'h0 : ref_load(f3, alu, rdata));
      @(posedge clk); #1;
      for (int w = 0; w <= waits; w++) begin
        dmem_ack   = (w == waits);
        dmem_rdata = (w == waits) ? rdata : $urandom;
        #1;
        chk({tag, ".req"}, dmem_req, 1);
        chk({tag, ".addr"}, dmem_addr, alu & ~32'h3);
        chk({tag, ".we"}, dmem_we, st);
        chk({tag, ".wstrb"}, dmem_wstrb, st ? ref_wstrb(f3, alu) : 4'b0);
        if (st) chk({tag, ".wdata"}, dmem_wdata, ref_wdata(f3, rs2));
        chk({tag, ".stall_busy"}, mem_stall, (w != waits));
        chk({tag, ".wb_bubble"}, MEM_WB_valid, 0);
        if (w != waits) begin @(posedge clk); #1; end
      end
      @(posedge clk); #1; dmem_ack = 1'b0; EX_MEM_valid = 1'b0; #1;
      chk({tag, ".wb_valid"}, MEM_WB_valid, 1);
      chk({tag, ".wb_sel"}, MEM_WB_reg_wb_sel, 1);
      chk({tag, ".wb_wen"}, MEM_WB_reg_write_en, st ? 1'b0 : rwe);
      chk({tag, ".wb_rd"}, MEM_WB_rd, rd);
      got = exp_q.pop_front();
      if (!st) chk({tag, ".wb_data"}, MEM_WB_alu_out, got);
      chk({tag, ".req_drop"}, dmem_req, 0);
      chk({tag, ".misalign"}, misalign_err, 0);
    end
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    int          kind;
    bit          rd_op, wr_op;
    // Reset
    reset_n = 1'b0;
    EX_MEM_valid = 0; EX_MEM_mem_read = 0; EX_MEM_mem_write = 0; EX_MEM_funct3 = 0;
    EX_MEM_alu_out = 0; EX_MEM_rs2_data = 0; EX_MEM_reg_write_en = 0; EX_MEM_rd = 0;
    dmem_ack = 0; dmem_rdata = 0;
    #3;
    chk("rst.req", dmem_req, 0);
    chk("rst.wstrb", dmem_wstrb, 0);
    chk("rst.wb_valid", MEM_WB_valid, 0);
    chk("rst.misalign", misalign_err, 0);
    chk("rst.stall", mem_stall, 0);
    chk("rst.state", fsm_state, 0);
    @(posedge clk); #1; reset_n = 1'b1;
    @(posedge clk); #1;

    // Ack in IDLE is ignored
    dmem_ack = 1'b1;
    @(posedge clk); #1; dmem_ack = 1'b0; #1;
    chk("idle_ack.req", dmem_req, 0);
    chk("idle_ack.state", fsm_state, 0);
    chk("idle_ack.wb_valid", MEM_WB_valid, 0);

    // Directed cases
    do_op("alu_pass", 1, 0, 0, 3'd0, 32'h1234, 32'h0, 1, 5'd5, 0, 32'h0);
    do_op("lb_sext", 1, 1, 0, 3'd0, 32'h103, 32'h0, 1, 5'd7, 3, 32'h80FFFFFF);
    do_op("lbu_zext", 1, 1, 0, 3'd4, 32'h103, 32'h0, 1, 5'd8, 0, 32'h80FFFFFF);
    do_op("sh_upper", 1, 0, 1, 3'd1, 32'h206, 32'hAAAABEEF, 1, 5'd9, 0, 32'h0);
    do_op("lw_misalign", 1, 1, 0, 3'd2, 32'h101, 32'h0, 1, 5'd10, 0, 32'h0);
    do_op("bubble", 0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 5'd0, 0, 32'h0);

    // Back-to-back: two request pulses in order, one retirement each
    req_pulses = 0; retires = 0; req_addr_q.delete();
    do_op("b2b_lw", 1, 1, 0, 3'd2, 32'h10, 32'h0, 1, 5'd11, 1, 32'hCAFEF00D);
    do_op("b2b_sw", 1, 0, 1, 3'd2, 32'h14, 32'h12345678, 1, 5'd12, 1, 32'h0);
    @(negedge clk); #1;
    chk("b2b.pulses", req_pulses, 2);
    chk("b2b.retires", retires, 2);
    chk("b2b.addr0", (req_addr_q.size() > 0) ? req_addr_q[0] : 32'hDEAD, 32'h10);
    chk("b2b.addr1", (req_addr_q.size() > 1) ? req_addr_q[1] : 32'hDEAD, 32'h14);

    // Reset mid-access
    EX_MEM_valid = 1; EX_MEM_mem_read = 1; EX_MEM_mem_write = 0; EX_MEM_funct3 = 3'd2;
    EX_MEM_alu_out = 32'h40; EX_MEM_reg_write_en = 1; EX_MEM_rd = 5'd3;
    @(posedge clk); #1;
    chk("rst_busy.req_before", dmem_req, 1);
    reset_n = 1'b0; #1;
    chk("rst_busy.req_drop", dmem_req, 0);
    chk("rst_busy.state", fsm_state, 0);
    EX_MEM_valid = 0;
    @(posedge clk); #1; reset_n = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h55AA55AA;
    @(posedge clk); #1; dmem_ack = 1'b0; #1;
    chk("rst_busy.late_ack_valid", MEM_WB_valid, 0);
    chk("rst_busy.late_ack_state", fsm_state, 0);
    chk("rst_busy.late_ack_req", dmem_req, 0);

    // Randomized mix
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      if (kind == 2 && $urandom_range(0, 1) == 1 && f3 < 3'd2) f3 = f3 + 3'd4;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'((1 << f3[1:0]) - 1);
      rd_op = (kind == 2) || (kind == 3 && $urandom_range(0, 1) == 1);
      wr_op = (kind == 3);
      do_op($sformatf("rnd%0d", i), kind != 0, rd_op, wr_op, f3, a, $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom_range(0, 3),
            $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
